fdram_rd_arbiter: RTL

Arbitrates the single frame-data BRAM read port between REQ_NUM PC-receive consumers (instruct parser, config parser, etc.) using the existing req/ack/done handshake. Round-robin grant, one owner at a time. The owner's read address is muxed onto the BRAM. Read data is broadcast to all consumers. Sits between the pc_rx consumer modules and the frame-data BRAM read port.

---
 rtl/fdram_rd_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/fdram_rd_arbiter.sv
// fdram_rd_arbiter: round-robin owner arbiter for the frame-data BRAM read port; FDRAM_ARB_TIMEOUT_EN adds forced release after TIMEOUT_CYC hold cycles
module fdram_rd_arbiter #(
  parameter int REQ_NUM     = 4,
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk_sys,
  input  logic                      rst,
  input  logic [REQ_NUM-1:0]        req_vec,
  output logic [REQ_NUM-1:0]        ack_vec,
  input  logic [REQ_NUM-1:0]        done_vec,
  input  logic [REQ_NUM*ADDR_W-1:0] rd_addr_vec,
  output logic [7:0]                rd_data_out,
  output logic [ADDR_W-1:0]         fdram_rd_addr,
  input  logic [7:0]                fdram_rd_data,
  output logic [2:0]                owner_idx,
  output logic                      busy,
  output logic                      timeout_err
);
  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;
  state_t     state_q, state_d;
  logic [2:0] owner_q, owner_d, rr_q, rr_d, pick, nxt;
  logic       any_req, done_own, tout, rel;
  int         j;
  // first requester at or above rr_q, wrapping; downward scan so the nearest one wins
  always_comb begin
    pick    = rr_q;
    any_req = |req_vec;
    j       = 0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      j = (j >= REQ_NUM) ? j - REQ_NUM : j;
      if (req_vec[j]) pick = 3'(j);
    end
  end
  // owner-indexed views: done from the owner, ack pulse, address mux
  always_comb begin
    done_own      = 1'b0;
    ack_vec       = '0;
    fdram_rd_addr = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (owner_q == 3'(i)) begin
        done_own      = done_vec[i];
        ack_vec[i]    = (state_q == GRANT);
        fdram_rd_addr = busy ? rd_addr_vec[i*ADDR_W +: ADDR_W] : '0;
      end
    end
  end
  assign busy        = (state_q != IDLE);
  assign owner_idx   = owner_q;
  assign rd_data_out = fdram_rd_data;
  assign nxt         = (owner_q == 3'(REQ_NUM - 1)) ? 3'd0 : owner_q + 3'd1;
  assign rel         = busy && (done_own || tout);
  // next state: grant from IDLE, release on owner done or timeout, GRANT lasts one cycle
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    if (state_q == IDLE && any_req) begin
      state_d = GRANT;
      owner_d = pick;
    end else if (rel) begin
      state_d = IDLE;
      rr_d    = nxt;
    end else if (state_q == GRANT) begin
      state_d = BUSY;
    end
  end
  // state register
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end
`ifdef FDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;
  logic          terr_q;
  assign tout        = busy && !done_own && (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign timeout_err = terr_q;
  // hold counter is zero on the ack cycle and counts every owned cycle
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= busy ? cnt_q + CW'(1) : '0;
      terr_q <= tout;
    end
  end
`else
  assign tout        = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule
